sha1_arbiter: RTL and testbench

Round-robin front end that shares one `SHA1` single-block hash core among `N_REQ` requesters. It accepts one 512-bit pre-padded block per grant, sequences the core's `START`/`DONE` handshake, and returns the 160-bit digest tagged with the requester ID. A watchdog reports an error if the core never answers. The block sits between the client ports and the single `SHA1` instance.

---
 rtl/sha1_pkg.sv | 23 ++
 rtl/sha1_arbiter_rr_pick.sv | 38 +++
 rtl/sha1_arbiter.sv | 158 +++++++++++++++
 tb/tb_sha1_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA1 front end and its benches.
//   SHA1_BLK_W / SHA1_DIG_W : core block and digest widths
//   arb_state_e             : arbiter FSM states
//   SHA1_DIG_EMPTY/ABC      : reference digests of "" and "abc"
package sha1_pkg;

   localparam int SHA1_BLK_W = 512;
   localparam int SHA1_DIG_W = 160;
   localparam int WDOG_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   localparam logic [SHA1_DIG_W-1:0] SHA1_DIG_EMPTY =
      160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [SHA1_DIG_W-1:0] SHA1_DIG_ABC =
      160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

endpackage

// File: rtl/sha1_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req     : request vector
//   ptr     : last granted requester; search starts at ptr+1 and wraps
//   win_vld : some request is present
//   win_oh  : one-hot winner
//   win_id  : winner index
module rr_pick
   import sha1_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             win_vld,
   output logic [N_REQ-1:0] win_oh,
   output logic [ID_W-1:0]  win_id
);

   logic [ID_W-1:0] idx;

   always_comb begin
      win_vld = 1'b0;
      win_oh  = '0;
      win_id  = '0;
      idx     = '0;
      // k = N_REQ lands back on ptr itself, so a lone repeat requester still wins
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % N_REQ);
         if (!win_vld && req[idx]) begin
            win_vld     = 1'b1;
            win_oh[idx] = 1'b1;
            win_id      = idx;
         end
      end
   end

endmodule

// File: rtl/sha1_arbiter.sv
// Round-robin front end sharing one SHA1 single-block core among N_REQ clients.
//   CLK, nRST        : clock, async active-low reset
//   REQ, REQ_DATA    : per-client request level and 512-bit block
//   GNT              : one-hot accept pulse
//   CORE_START/IN    : launch strobe and block to the core
//   CORE_DONE/OUT    : completion pulse and digest from the core
//   RSP_*            : tagged response pulse (digest 0 + ERR on watchdog expiry)
//   BUSY             : any state other than IDLE
//
// state  | meaning
// IDLE   | arbitrate; accept the winner's block
// LAUNCH | hold CORE_START for START_CYC cycles; GNT in the first one
// WAIT   | watchdog runs until CORE_DONE or expiry
// RESP   | one-cycle response pulse
module sha1_arbiter
   import sha1_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int START_CYC = 2,
   parameter int TIMEOUT   = 1000
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic [N_REQ-1:0]              REQ,
   input  logic [N_REQ*SHA1_BLK_W-1:0]   REQ_DATA,
   output logic [N_REQ-1:0]              GNT,
   output logic                          CORE_START,
   output logic [SHA1_BLK_W-1:0]         CORE_IN,
   input  logic                          CORE_DONE,
   input  logic [SHA1_DIG_W-1:0]         CORE_OUT,
   output logic                          RSP_VALID,
   output logic [$clog2(N_REQ)-1:0]      RSP_ID,
   output logic [SHA1_DIG_W-1:0]         RSP_DIGEST,
   output logic                          RSP_ERR,
   output logic                          BUSY
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_e             state_q, state_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic [ID_W-1:0]        id_q, id_d;
   logic [WDOG_W-1:0]      cnt_q, cnt_d;
   logic [SHA1_BLK_W-1:0]  core_in_q, core_in_d;
   logic [SHA1_DIG_W-1:0]  digest_q, digest_d;
   logic                   err_q, err_d;
   logic [N_REQ-1:0]       gnt_q, gnt_d;
   logic                   start_q, start_d;
   logic                   rsp_vld_q, rsp_vld_d;
   logic                   busy_q, busy_d;

   logic                   win_vld;
   logic [N_REQ-1:0]       win_oh;
   logic [ID_W-1:0]        win_id;
   logic [SHA1_BLK_W-1:0]  blk [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_blk
      assign blk[g] = REQ_DATA[g*SHA1_BLK_W +: SHA1_BLK_W];
   end

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req     (REQ),
      .ptr     (ptr_q),
      .win_vld (win_vld),
      .win_oh  (win_oh),
      .win_id  (win_id)
   );

   // cnt_q is shared: LAUNCH length down-count, then the WAIT watchdog.
   // Watchdog is loaded with TIMEOUT and expires one edge after reaching 0,
   // giving TIMEOUT+1 WAIT cycles before the error response.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      core_in_d = core_in_q;
      digest_d  = digest_q;
      err_d     = err_q;
      gnt_d     = '0;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d   = LAUNCH;
               ptr_d     = win_id;
               id_d      = win_id;
               core_in_d = blk[win_id];
               gnt_d     = win_oh;
               cnt_d     = WDOG_W'(START_CYC - 1);
            end
         end
         LAUNCH: begin
            if (cnt_q == '0) begin
               state_d = WAIT;
               cnt_d   = WDOG_W'(TIMEOUT);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT: begin
            if (CORE_DONE) begin
               state_d  = RESP;
               digest_d = CORE_OUT;
               err_d    = 1'b0;
            end else if (cnt_q == '0) begin
               state_d  = RESP;
               digest_d = '0;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      start_d   = (state_d == LAUNCH);
      rsp_vld_d = (state_d == RESP);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         ptr_q     <= ID_W'(N_REQ - 1);
         id_q      <= '0;
         cnt_q     <= '0;
         core_in_q <= '0;
         digest_q  <= '0;
         err_q     <= 1'b0;
         gnt_q     <= '0;
         start_q   <= 1'b0;
         rsp_vld_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         core_in_q <= core_in_d;
         digest_q  <= digest_d;
         err_q     <= err_d;
         gnt_q     <= gnt_d;
         start_q   <= start_d;
         rsp_vld_q <= rsp_vld_d;
         busy_q    <= busy_d;
      end
   end

   assign GNT        = gnt_q;
   assign CORE_START = start_q;
   assign CORE_IN    = core_in_q;
   assign RSP_VALID  = rsp_vld_q;
   assign RSP_ID     = id_q;
   assign RSP_DIGEST = digest_q;
   assign RSP_ERR    = err_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_sha1_arbiter.sv
// Bench for sha1_arbiter: behavioural core model plus a reference model of
// round-robin service, response contents and response timing.
module tb_sha1_arbiter;
   import sha1_pkg::*;

   localparam int N  = 4;
   localparam int SC = 2;
   localparam int TO = 20;

   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};

   logic              CLK = 1'b0;
   logic              nRST;
   logic [N-1:0]      REQ;
   logic [N*512-1:0]  REQ_DATA;
   logic [N-1:0]      GNT;
   logic              CORE_START;
   logic [511:0]      CORE_IN;
   logic              CORE_DONE;
   logic [159:0]      CORE_OUT;
   logic              RSP_VALID;
   logic [1:0]        RSP_ID;
   logic [159:0]      RSP_DIGEST;
   logic              RSP_ERR;
   logic              BUSY;

   sha1_arbiter #(.N_REQ(N), .START_CYC(SC), .TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
      .CORE_START(CORE_START), .CORE_IN(CORE_IN), .CORE_DONE(CORE_DONE),
      .CORE_OUT(CORE_OUT), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID),
      .RSP_DIGEST(RSP_DIGEST), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int           id;
      logic [159:0] dig;
      bit           err;
   } rsp_t;

   int n_cmp = 0, n_bad = 0;
   bit           pending [N];
   bit           in_flight [N];
   logic [511:0] blk [N];
   int           last_win;
   logic [511:0] exp_core_in;
   bit           active, prev_start, core_mute;
   int           start_cnt, done_cnt, lat_min, lat_max, exp_lat, fall_cyc, cyc;
   int           req_pct, blk_mode, rsp_seen, last_id;
   bit           toggle_en, last_err;
   logic [159:0] last_dig;
   rsp_t         rsp_q [$];
   int           gnt_log [$];

   task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [159:0] core_fn(input logic [511:0] b);
      if (b == BLK_EMPTY) return SHA1_DIG_EMPTY;
      if (b == BLK_ABC)   return SHA1_DIG_ABC;
      return b[159:0] ^ b[319:160] ^ b[479:320];
   endfunction

   function automatic logic [511:0] rand_blk();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] new_blk();
      int m = blk_mode;
      if (m == 3) m = $urandom_range(2);
      if (m == 1) return BLK_EMPTY;
      if (m == 2) return BLK_ABC;
      return rand_blk();
   endfunction

   // Next requester after 'last' in circular order that is currently asking.
   function automatic int rr_next(input int last);
      for (int k = 1; k <= N; k++)
         if (pending[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic bit any_pending();
      for (int i = 0; i < N; i++) if (pending[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic apply_req();
      for (int i = 0; i < N; i++) begin
         REQ[i] = pending[i];
         REQ_DATA[i*512 +: 512] = blk[i];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         pending[i]   = 1'b0;
         in_flight[i] = 1'b0;
      end
      rsp_q.delete();
      last_win    = N - 1;
      exp_core_in = '0;
      active      = 1'b0;
      prev_start  = 1'b0;
      start_cnt   = 0;
   endtask

   task automatic step();
      int           w, j;
      logic [N-1:0] exp_oh;
      rsp_t         r;
      @(negedge CLK);
      cyc++;
      // observe
      if (GNT !== '0) begin
         w = rr_next(last_win);
         exp_oh = '0;
         if (w >= 0) exp_oh[w] = 1'b1;
         check_eq("gnt_onehot", GNT, exp_oh);
         check_eq("gnt_while_busy", active, 1'b0);
         if (w >= 0) begin
            gnt_log.push_back(w);
            last_win     = w;
            active       = 1'b1;
            start_cnt    = 0;
            exp_core_in  = blk[w];
            pending[w]   = 1'b0;
            in_flight[w] = 1'b1;
            r.id  = w;
            r.err = core_mute;
            r.dig = core_mute ? 160'h0 : core_fn(blk[w]);
            rsp_q.push_back(r);
         end
      end
      if (CORE_START) begin
         start_cnt++;
         check_eq("start_outside_job", active, 1'b1);
      end
      if (prev_start && !CORE_START) begin
         check_eq("start_len", start_cnt, SC);
         fall_cyc = cyc;
         if (core_mute) exp_lat = TO + 1;
         else begin
            j        = $urandom_range(lat_max, lat_min);
            done_cnt = j;
            exp_lat  = j + 1;
         end
      end
      prev_start = CORE_START;
      check_eq("core_in", CORE_IN, exp_core_in);
      if (RSP_VALID) begin
         rsp_seen++;
         last_id  = RSP_ID;
         last_dig = RSP_DIGEST;
         last_err = RSP_ERR;
         if (rsp_q.size() == 0) check_eq("rsp_unexpected", RSP_VALID, 1'b0);
         else begin
            r = rsp_q.pop_front();
            check_eq("rsp_id", RSP_ID, r.id);
            check_eq("rsp_digest", RSP_DIGEST, r.dig);
            check_eq("rsp_err", RSP_ERR, r.err);
            check_eq("rsp_latency", cyc - fall_cyc, exp_lat);
            check_eq("busy_resp", BUSY, 1'b1);
            in_flight[r.id] = 1'b0;
            active = 1'b0;
         end
      end else begin
         check_eq("busy", BUSY, active);
      end
      // core model
      if (done_cnt == 0) begin
         CORE_DONE = 1'b1;
         CORE_OUT  = core_fn(CORE_IN);
      end else begin
         CORE_DONE = 1'b0;
         CORE_OUT  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (done_cnt >= 0) done_cnt--;
      // requesters
      for (int i = 0; i < N; i++) begin
         if (!pending[i] && !in_flight[i]) begin
            if ($urandom_range(99) < req_pct) begin
               pending[i] = 1'b1;
               blk[i]     = new_blk();
            end else if (toggle_en) blk[i] = rand_blk();
         end else if (in_flight[i] && toggle_en) blk[i] = rand_blk();
      end
      apply_req();
   endtask

   task automatic raise(input int i, input logic [511:0] b);
      pending[i] = 1'b1;
      blk[i]     = b;
      apply_req();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((any_pending() || active || rsp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check_eq("drain_in_budget", n < budget, 1'b1);
      repeat (3) step();
   endtask

   task automatic reach_wait();
      int n = 0;
      do begin
         step();
         n++;
      end while (!(active && start_cnt == SC && !prev_start) && n < 100);
      check_eq("reach_wait", n < 100, 1'b1);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_gnt", GNT, '0);
      check_eq("rst_core_start", CORE_START, 1'b0);
      check_eq("rst_core_in", CORE_IN, '0);
      check_eq("rst_rsp_valid", RSP_VALID, 1'b0);
      check_eq("rst_rsp_id", RSP_ID, '0);
      check_eq("rst_rsp_digest", RSP_DIGEST, '0);
      check_eq("rst_rsp_err", RSP_ERR, 1'b0);
      check_eq("rst_busy", BUSY, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int base, mark, cnt1;
      int exp_ord [5] = '{0, 1, 2, 3, 0};
      nRST = 1'b1; REQ = '0; REQ_DATA = '0; CORE_DONE = 1'b0; CORE_OUT = '0;
      for (int i = 0; i < N; i++) blk[i] = '0;
      model_reset();
      done_cnt = -1; core_mute = 1'b0; lat_min = 0; lat_max = TO - 1;
      req_pct = 0; blk_mode = 0; toggle_en = 1'b0; cyc = 0; rsp_seen = 0;
      #2 nRST = 1'b0;
      repeat (3) step();
      check_reset_outputs();
      nRST = 1'b1;
      repeat (2) step();

      // single job, "abc"
      base = gnt_log.size();
      raise(2, BLK_ABC);
      drain(200);
      check_eq("single_gnt_count", gnt_log.size() - base, 1);
      check_eq("single_gnt_id", gnt_log[base], 2);
      check_eq("single_rsp_id", last_id, 2);
      check_eq("single_rsp_err", last_err, 1'b0);
      check_eq("single_digest", last_dig, SHA1_DIG_ABC);

      // reset mid-WAIT; the core's late DONE must not produce a response
      lat_min = 15; lat_max = 15;
      raise(3, rand_blk());
      reach_wait();
      repeat (3) step();
      nRST = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      apply_req();
      repeat (3) step();
      nRST = 1'b1;
      mark = rsp_seen;
      repeat (30) step();
      check_eq("no_rsp_after_reset", rsp_seen - mark, 0);

      // contention, empty-string blocks, immediate re-request
      lat_min = 0; lat_max = TO - 1;
      blk_mode = 1; req_pct = 100;
      base = gnt_log.size();
      for (int n = 0; n < 400 && gnt_log.size() < base + 5; n++) step();
      req_pct = 0;
      drain(400);
      check_eq("contend_gnt_count", gnt_log.size() - base >= 5, 1'b1);
      for (int k = 0; k < 5; k++)
         if (gnt_log.size() > base + k) check_eq("contend_order", gnt_log[base + k], exp_ord[k]);
      check_eq("contend_digest", last_dig, SHA1_DIG_EMPTY);

      // timeout, then a late DONE
      core_mute = 1'b1;
      raise(1, rand_blk());
      drain(200);
      check_eq("to_rsp_id", last_id, 1);
      check_eq("to_rsp_err", last_err, 1'b1);
      check_eq("to_rsp_digest", last_dig, '0);
      core_mute = 1'b0;
      mark = rsp_seen;
      done_cnt = 2;
      repeat (10) step();
      check_eq("late_done_dropped", rsp_seen - mark, 0);

      // withdraw before grant, with data toggling during the job
      lat_min = 15; lat_max = 15; toggle_en = 1'b1;
      base = gnt_log.size();
      raise(0, rand_blk());
      reach_wait();
      raise(1, rand_blk());
      repeat (3) step();
      pending[1] = 1'b0;
      apply_req();
      drain(200);
      cnt1 = 0;
      for (int k = base; k < gnt_log.size(); k++) if (gnt_log[k] == 1) cnt1++;
      check_eq("withdrawn_never_granted", cnt1, 0);

      // randomized traffic
      lat_min = 0; lat_max = TO - 1; blk_mode = 3; req_pct = 15;
      repeat (600) step();
      req_pct = 0;
      drain(1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
